bank_rw_init: RTL

- Parametrised successor to the single-port register bank.
- Synchronous single-port memory with configurable data width and depth, per-byte write mask, and a 1-cycle registered read with valid strobe.
- Write-first read-during-write.
- Hardware clear sweep after reset releases: memory is zeroed one word per cycle, then the block signals ready.
- Sits between the core load/store path and shared data storage.

---
 rtl/bank_rw_init.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bank_rw_init.sv
// Single-port word memory with per-byte write mask, 1-cycle registered read,
// write-first read-during-write and a zeroing sweep after reset releases.
// Optional per-byte even parity with a parity_err output: BANK_RW_INIT_PARITY_EN.
module bank_rw_init #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8,
   localparam int BE_W  = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic [BE_W-1:0]   byte_en,
   input  logic              read_enable,
   input  logic              write_enable,
   output logic              ready,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid
`ifdef BANK_RW_INIT_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_CLEAR = 2'd1,
      ST_READY = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [BE_W-1:0]   be);
      logic [DATA_W-1:0] res;
      for (int i = 0; i < BE_W; i++) begin
         res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      end
      return res;
   endfunction

   function automatic logic [BE_W-1:0] byte_parity(input logic [DATA_W-1:0] w);
      logic [BE_W-1:0] p;
      for (int i = 0; i < BE_W; i++) begin
         p[i] = ^w[8*i +: 8];
      end
      return p;
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                ready_q;
   logic [DATA_W-1:0]   data_out_q;
   logic                rd_valid_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                in_range_s;
   logic                accept_s;
   logic                wr_hit_s;
   logic                rd_hit_s;
   logic [DATA_W-1:0]   old_word_s;
   logic [DATA_W-1:0]   merged_s;

   // Request qualification and the write-first merged word
   always_comb begin
      in_range_s = ({1'b0, addr} < DEPTH_L);
      accept_s   = (state_q == ST_READY);
      wr_hit_s   = accept_s && write_enable && in_range_s && (|byte_en);
      rd_hit_s   = accept_s && read_enable;
      if (in_range_s) begin
         old_word_s = mem_q[addr];
      end else begin
         old_word_s = '0;
      end
      if (wr_hit_s) begin
         merged_s = merge_bytes(old_word_s, data_in, byte_en);
      end else begin
         merged_s = old_word_s;
      end
   end

   // Next-state logic for the reset / clear / ready sequence
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RST: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
         ST_CLEAR: begin
            cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (cnt_q == LAST_L) begin
               state_d = ST_READY;
            end else begin
               state_d = ST_CLEAR;
            end
         end
         ST_READY: begin
            state_d = ST_READY;
         end
         default: begin
            state_d = ST_RST;
            cnt_d   = '0;
         end
      endcase
   end

   // Control and read-port registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_RST;
         cnt_q      <= '0;
         ready_q    <= 1'b0;
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ready_q    <= (state_d == ST_READY);
         rd_valid_q <= rd_hit_s;
         if (rd_hit_s) begin
            data_out_q <= merged_s;
         end
      end
   end

   // Storage array; the reset cycle itself leaves contents untouched
   always_ff @(posedge clk) begin
      if (reset) begin
         if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= '0;
         end else if (wr_hit_s) begin
            mem_q[addr] <= merged_s;
         end
      end
   end

   assign ready    = ready_q;
   assign data_out = data_out_q;
   assign rd_valid = rd_valid_q;

`ifdef BANK_RW_INIT_PARITY_EN
   logic [BE_W-1:0] par_q [DEPTH];
   logic [BE_W-1:0] old_par_s;
   logic            parity_err_q;
   logic            parity_err_d;

   // Stored parity lookup and check; a read-during-write sees fresh parity
   always_comb begin
      if (in_range_s) begin
         old_par_s = par_q[addr];
      end else begin
         old_par_s = '0;
      end
      if (rd_hit_s && in_range_s && !wr_hit_s) begin
         parity_err_d = |(byte_parity(old_word_s) ^ old_par_s);
      end else begin
         parity_err_d = 1'b0;
      end
   end

   // Parity storage, only written bytes get new parity bits
   always_ff @(posedge clk) begin
      if (reset) begin
         if (state_q == ST_CLEAR) begin
            par_q[cnt_q] <= '0;
         end else if (wr_hit_s) begin
            par_q[addr] <= (byte_parity(merged_s) & byte_en) | (old_par_s & ~byte_en);
         end
      end
   end

   // Parity error flag registered alongside data_out
   always_ff @(posedge clk) begin
      if (!reset) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`endif

endmodule
